// File: rtl/sev_seg_scan.sv
// rtl/sev_seg_scan.sv - multiplexed seven-segment scanner with tear-free frame loading
// Prescaled digit scan, hex/decimal glyphs, leading-zero suppression, registered outputs.
module sev_seg_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    hex_en,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_valid;
   logic [4*NUM_DIGITS-1:0] disp_val;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic                    tick;
   logic                    wrap;
   logic [3:0]              cur_nib;
   logic                    above_zero;
   logic                    suppress;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   assign tick = (presc == PRESC_MAX);
   assign wrap = tick && (idx == IDX_MAX);

   always_comb begin
      cur_nib    = disp_val[4*idx +: 4];
      // Digit is a leading zero when it and every digit above it are zero.
      above_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx) && disp_val[4*j +: 4] != 4'd0)
            above_zero = 1'b0;
      end
      suppress = lz_blank && (idx != '0) && above_zero;
      seg_nxt  = 7'b1111111;
      dp_nxt   = 1'b1;
      if (!suppress) begin
         if (hex_en || cur_nib <= 4'd9)
            seg_nxt = glyph(cur_nib);
         dp_nxt = ~disp_dp[idx];
      end
      an_nxt = ~(NUM_DIGITS'(1) << idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
         end
         // A load coinciding with the wrap keeps pending_valid set for the next frame.
         if (wrap && pend_valid) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            if (!load)
               pend_valid <= 1'b0;
         end
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         an         <= an_nxt;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_sev_seg_scan.sv
// tb/tb_sev_seg_scan.sv - directed self-checking bench for sev_seg_scan
// NUM_DIGITS=4, CLK_DIV=4: each digit lasts 4 cycles, a frame lasts 16 cycles.
module tb_sev_seg_scan;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110;
   localparam logic [6:0] GX = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_in = '0;
   logic        hex_en = 1'b0;
   logic        lz_blank = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   sev_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .dp_in      (dp_in),
      .hex_en     (hex_en),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; sampled on negedges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic wait_to(input int k);
      int guard;
      guard = 0;
      while (cyc < k) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_to timeout cyc=%0d required=%0d", cyc, k);
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load = 1'b0;
      value = '0;
      dp_in = '0;
      hex_en = 1'b0;
      lz_blank = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (seg !== GX) begin errors++; $display("FAIL rst_seg got=%b exp=%b", seg, GX); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got=%b exp=1", dp); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an got=%b exp=1111", an); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
      rst_n = 1'b1;
      wait_to(1);
      checks++; if (seg !== G0) begin errors++; $display("FAIL rst_first_seg got=%b exp=%b", seg, G0); end
      checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rst_first_an got=%b exp=1110", an); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_first_dp got=%b exp=1", dp); end
   endtask

   task automatic test_scan();
      logic [3:0] one;
      logic [3:0] exp_an;
      logic       exp_fd;
      int         pulses;
      one = 4'b0001;
      pulses = 0;
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         wait_to(k);
         exp_an = ~(one << (((k - 1) / 4) % 4));
         exp_fd = (k == 16);
         if (frame_done === 1'b1) pulses++;
         checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, exp_an); end
         checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_fd k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL scan_fd_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_load_mid_frame();
      logic [6:0] exp_seg [4];
      logic [3:0] one;
      one = 4'b0001;
      exp_seg = '{G4, G3, G2, G1};
      do_reset();
      wait_to(5);
      value = 16'h1234; load = 1'b1;
      wait_to(6);
      load = 1'b0; value = 16'hFFFF;
      wait_to(8);
      checks++; if (seg !== G0) begin errors++; $display("FAIL mid_old_d1 got=%b exp=%b", seg, G0); end
      wait_to(16);
      checks++; if (seg !== G0) begin errors++; $display("FAIL mid_old_d3 got=%b exp=%b", seg, G0); end
      for (int d = 0; d < 4; d++) begin
         wait_to(18 + 4 * d);
         checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL mid_new_seg d=%0d got=%b exp=%b", d, seg, exp_seg[d]); end
         checks++; if (an !== ~(one << d)) begin errors++; $display("FAIL mid_new_an d=%0d got=%b exp=%b", d, an, ~(one << d)); end
      end
   endtask

   task automatic test_hex_mode();
      do_reset();
      wait_to(1);
      value = 16'h00A5; dp_in = 4'b0010; load = 1'b1;
      wait_to(2);
      load = 1'b0;
      wait_to(18);
      checks++; if (seg !== G5) begin errors++; $display("FAIL hex_d0 got=%b exp=%b", seg, G5); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL hex_d0_dp got=%b exp=1", dp); end
      wait_to(22);
      checks++; if (seg !== GX) begin errors++; $display("FAIL hex_d1_blank got=%b exp=%b", seg, GX); end
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL hex_d1_dp got=%b exp=0", dp); end
      hex_en = 1'b1;
      wait_to(23);
      checks++; if (seg !== GA) begin errors++; $display("FAIL hex_d1_a got=%b exp=%b", seg, GA); end
      wait_to(26);
      checks++; if (seg !== G0) begin errors++; $display("FAIL hex_d2 got=%b exp=%b", seg, G0); end
      hex_en = 1'b0;
   endtask

   task automatic test_lz_blank();
      do_reset();
      lz_blank = 1'b1;
      wait_to(1);
      value = 16'h0007; dp_in = 4'b1111; load = 1'b1;
      wait_to(2);
      load = 1'b0;
      wait_to(18);
      checks++; if (seg !== G7) begin errors++; $display("FAIL lz_d0 got=%b exp=%b", seg, G7); end
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL lz_d0_dp got=%b exp=0", dp); end
      for (int d = 1; d < 4; d++) begin
         wait_to(18 + 4 * d);
         checks++; if (seg !== GX) begin errors++; $display("FAIL lz_blank_seg d=%0d got=%b exp=%b", d, seg, GX); end
         checks++; if (dp !== 1'b1) begin errors++; $display("FAIL lz_blank_dp d=%0d got=%b exp=1", d, dp); end
      end
      wait_to(30);
      value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
      wait_to(31);
      load = 1'b0;
      wait_to(34);
      checks++; if (seg !== G0) begin errors++; $display("FAIL lz_zero_d0 got=%b exp=%b", seg, G0); end
      for (int d = 1; d < 4; d++) begin
         wait_to(34 + 4 * d);
         checks++; if (seg !== GX) begin errors++; $display("FAIL lz_zero_seg d=%0d got=%b exp=%b", d, seg, GX); end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_load_on_wrap();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      exp_a = '{G8, G7, G6, G5};
      exp_b = '{GC, GB, GA, G9};
      do_reset();
      hex_en = 1'b1;
      wait_to(9);
      value = 16'h5678; load = 1'b1;
      wait_to(10);
      load = 1'b0;
      wait_to(15);
      value = 16'h9ABC; load = 1'b1;
      wait_to(16);
      load = 1'b0;
      checks++; if (seg !== G0) begin errors++; $display("FAIL wrap_frame0 got=%b exp=%b", seg, G0); end
      for (int d = 0; d < 4; d++) begin
         wait_to(18 + 4 * d);
         checks++; if (seg !== exp_a[d]) begin errors++; $display("FAIL wrap_frame1 d=%0d got=%b exp=%b", d, seg, exp_a[d]); end
      end
      for (int d = 0; d < 4; d++) begin
         wait_to(34 + 4 * d);
         checks++; if (seg !== exp_b[d]) begin errors++; $display("FAIL wrap_frame2 d=%0d got=%b exp=%b", d, seg, exp_b[d]); end
      end
      wait_to(50);
      checks++; if (seg !== GC) begin errors++; $display("FAIL wrap_frame3 got=%b exp=%b", seg, GC); end
      hex_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      wait_to(2);
      value = 16'h1111; load = 1'b1;
      wait_to(3);
      load = 1'b0;
      wait_to(8);
      value = 16'h2222; load = 1'b1;
      wait_to(9);
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
         wait_to(18 + 4 * d);
         checks++; if (seg !== G2) begin errors++; $display("FAIL b2b_last_load d=%0d got=%b exp=%b", d, seg, G2); end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      wait_to(5);
      value = 16'h4321; dp_in = 4'b1111; load = 1'b1;
      wait_to(6);
      load = 1'b0;
      wait_to(9);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (seg !== GX) begin errors++; $display("FAIL async_seg got=%b exp=%b", seg, GX); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got=%b exp=1", dp); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_an got=%b exp=1111", an); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL async_fd got=%b exp=0", frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_to(2);
      checks++; if (seg !== G0) begin errors++; $display("FAIL post_rst_d0 got=%b exp=%b", seg, G0); end
      wait_to(18);
      checks++; if (seg !== G0) begin errors++; $display("FAIL post_rst_frame1_d0 got=%b exp=%b", seg, G0); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL post_rst_frame1_dp got=%b exp=1", dp); end
      wait_to(30);
      checks++; if (seg !== G0) begin errors++; $display("FAIL post_rst_frame1_d3 got=%b exp=%b", seg, G0); end
      checks++; if (an !== 4'b0111) begin errors++; $display("FAIL post_rst_frame1_an got=%b exp=0111", an); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_mid_frame();
      test_hex_mode();
      test_lz_blank();
      test_load_on_wrap();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sev_seg_scan.md
SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter CLK_DIV, default 50000, meaning the clock cycles each digit is enabled (legal range ≥2).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port value, input, 4*NUM_DIGITS bits, meaning one nibble per digit; nibble k = value[4k+3:4k]; digit 0 = least significant.
REQ-006 The block SHALL have port load, input, 1 bit, meaning a single-cycle strobe that captures value and dp_in.
REQ-007 The block SHALL have port dp_in, input, NUM_DIGITS bits, meaning the per-digit decimal point request, active-high.
REQ-008 The block SHALL have port hex_en, input, 1 bit, meaning 1 = hex glyphs for nibbles A-F and 0 = decimal mode, in which nibbles >9 are blanked.
REQ-009 The block SHALL have port lz_blank, input, 1 bit, meaning 1 = leading-zero suppression enabled.
REQ-010 The block SHALL have port seg, output, 7 bits, meaning active-low segments, with seg[0]=a through seg[6]=g.
REQ-011 The block SHALL have port dp, output, 1 bit, meaning the active-low decimal point.
REQ-012 The block SHALL have port an, output, NUM_DIGITS bits, meaning one-hot-low digit enables.
REQ-013 The block SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse at the end of each full scan.

Function
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; digit index SHALL increment when prescaler = CLK_DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 When load=1, value and dp_in SHALL be captured into a pending register, and pending_valid SHALL be set.
REQ-016 Pending data SHALL transfer to the display register only on the cycle the index wraps NUM_DIGITS-1 -> 0 with pending_valid=1; pending_valid SHALL then clear, giving tear-free frames.
REQ-017 If load and frame wrap coincide, the display register SHALL take the previously pending data, the pending register SHALL take the new data, and pending_valid SHALL remain 1.
REQ-018 A later load before the frame wrap SHALL overwrite the pending data, so only the last load per frame is shown.
REQ-019 Glyphs SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, and blank=1111111.
REQ-020 When hex_en=0, nibbles A-F SHALL produce blank with dp unaffected.
REQ-021 When lz_blank=1, every digit above the most significant nonzero nibble SHALL be blank with its dp forced off; digit 0 SHALL never be suppressed.
REQ-022 The active digit k SHALL have an[k]=0 and all others 1; seg and dp SHALL show display nibble k and dp bit k.
REQ-023 seg, dp and an SHALL be registered, updating 1 cycle after the index changes; hex_en and lz_blank changes SHALL take effect 1 cycle later.
REQ-024 frame_done SHALL be registered and pulse high for exactly 1 cycle, the cycle after the NUM_DIGITS-1 -> 0 wrap.

Reset
REQ-025 While rst_n=0, the following SHALL hold: seg=1111111, dp=1, an all ones, frame_done=0, prescaler=0, index=0, display and pending registers 0, and pending_valid=0.
REQ-026 After rst_n is released, the first output update SHALL show digit 0 with glyph 0 (or blank where lz_blank suppresses it).
REQ-027 Reset asserted mid-frame SHALL immediately blank the outputs and discard pending data.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-028 Scenario 1: after reset release, hold 16 cycles -> an cycles 1110, 1101, 1011, 0111 at 4 cycles each; frame_done pulses once, 1 cycle after the wrap.
REQ-029 Scenario 2: load value=16'h1234 mid-frame -> old data persists until the wrap, then digits 0..3 show 4, 3, 2, 1 with seg 0011001, 0110000, 0100100, 1111001.
REQ-030 Scenario 3: value=16'h00A5 with hex_en=0 -> digit 1 is blank and digit 0 is 0010010; with hex_en=1, digit 1 is 0001000.
REQ-031 Scenario 4: value=16'h0007 with lz_blank=1 -> digits 3..1 show 1111111 and digit 0 shows 1111000; value=16'h0000 shows only digit 0 = 1000000.
REQ-032 Scenario 5: load on the exact wrap cycle with data B, with data A pending -> frame 1 shows A and frame 2 shows B.
REQ-033 Scenario 6: assert rst_n=0 mid-digit with pending data -> outputs blank asynchronously; after release, display shows 0 and the pending data never appears.
